// File: rtl/ceespu_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : ceespu_branch_resolver
//  Description : Carries gshare prediction metadata from fetch to execute and
//                resolves it against the real outcome (update/redirect/stats).
//  Revision    : 1.0
// ============================================================================
module ceespu_branch_resolver #(
    parameter int PC_WIDTH  = 14,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 I_stall,
    input  logic                 I_flush,
    input  logic                 I_fetch_valid,
    input  logic [PC_WIDTH-1:0]  I_fetch_PC,
    input  logic                 I_prediction,
    input  logic [1:0]           I_prediction_state,
    input  logic [PC_WIDTH-1:0]  I_predicted_target,
    input  logic                 I_ex_is_branch,
    input  logic                 I_ex_conditional,
    input  logic                 I_ex_taken,
    input  logic [PC_WIDTH-1:0]  I_ex_target,
    output logic                 update_table,
    output logic [PC_WIDTH-1:0]  branch_address,
    output logic [1:0]           branch_prediction_state,
    output logic                 branch_taken,
    output logic                 O_mispredict,
    output logic [PC_WIDTH-1:0]  O_redirect_PC,
    output logic [CNT_WIDTH-1:0] O_branch_count,
    output logic [CNT_WIDTH-1:0] O_mispredict_count
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0]  c_PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic                r_d_valid;
    logic [PC_WIDTH-1:0] r_d_pc;
    logic                r_d_pred;
    logic [1:0]          r_d_state;
    logic [PC_WIDTH-1:0] r_d_ptarget;

    logic                r_e_valid;
    logic [PC_WIDTH-1:0] r_e_pc;
    logic                r_e_pred;
    logic [1:0]          r_e_state;
    logic [PC_WIDTH-1:0] r_e_ptarget;

    logic                w_resolve;
    logic                w_mispredict;
    logic [PC_WIDTH-1:0] w_redirect_pc;

    // A taken branch predicted taken can still miss if the target was wrong.
    always_comb begin
        w_resolve     = r_e_valid & I_ex_is_branch & ~I_stall & ~I_flush;
        w_mispredict  = w_resolve &
                        ((I_ex_taken != r_e_pred) |
                         (I_ex_taken & r_e_pred & (I_ex_target != r_e_ptarget)));
        w_redirect_pc = I_ex_taken ? I_ex_target : (r_e_pc + c_PC_ONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_valid               <= 1'b0;
            r_d_pc                  <= '0;
            r_d_pred                <= 1'b0;
            r_d_state               <= '0;
            r_d_ptarget             <= '0;
            r_e_valid               <= 1'b0;
            r_e_pc                  <= '0;
            r_e_pred                <= 1'b0;
            r_e_state               <= '0;
            r_e_ptarget             <= '0;
            update_table            <= 1'b0;
            branch_address          <= '0;
            branch_prediction_state <= '0;
            branch_taken            <= 1'b0;
            O_mispredict            <= 1'b0;
            O_redirect_PC           <= '0;
            O_branch_count          <= '0;
            O_mispredict_count      <= '0;
        end else if (I_flush) begin
            r_d_valid    <= 1'b0;
            r_e_valid    <= 1'b0;
            update_table <= 1'b0;
            O_mispredict <= 1'b0;
        end else if (I_stall) begin
            update_table <= 1'b0;
            O_mispredict <= 1'b0;
        end else begin
            r_d_pc      <= I_fetch_PC;
            r_d_pred    <= I_prediction;
            r_d_state   <= I_prediction_state;
            r_d_ptarget <= I_predicted_target;
            r_e_pc      <= r_d_pc;
            r_e_pred    <= r_d_pred;
            r_e_state   <= r_d_state;
            r_e_ptarget <= r_d_ptarget;
            // Younger entries, including this cycle's fetch, are wrong-path.
            r_d_valid   <= I_fetch_valid & ~w_mispredict;
            r_e_valid   <= r_d_valid & ~w_mispredict;

            update_table <= w_resolve & I_ex_conditional;
            O_mispredict <= w_mispredict;

            if (w_resolve) begin
                branch_address          <= r_e_pc;
                branch_prediction_state <= r_e_state;
                branch_taken            <= I_ex_taken;
                if (O_branch_count != c_CNT_MAX) begin
                    O_branch_count <= O_branch_count + c_CNT_ONE;
                end
            end

            if (w_mispredict) begin
                O_redirect_PC <= w_redirect_pc;
                if (O_mispredict_count != c_CNT_MAX) begin
                    O_mispredict_count <= O_mispredict_count + c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ceespu_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ceespu_branch_resolver
//  Description : Randomized and directed bench for ceespu_branch_resolver
//                against a queue-based in-flight instruction model.
//  Revision    : 1.0
// ============================================================================
module tb_ceespu_branch_resolver;

    localparam int c_CNT_MAX = 65535;

    typedef struct packed {
        logic        v;
        logic [13:0] pc;
        logic        pred;
        logic [1:0]  st;
        logic [13:0] pt;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        I_stall = 1'b0;
    logic        I_flush = 1'b0;
    logic        I_fetch_valid = 1'b0;
    logic [13:0] I_fetch_PC = '0;
    logic        I_prediction = 1'b0;
    logic [1:0]  I_prediction_state = '0;
    logic [13:0] I_predicted_target = '0;
    logic        I_ex_is_branch = 1'b0;
    logic        I_ex_conditional = 1'b0;
    logic        I_ex_taken = 1'b0;
    logic [13:0] I_ex_target = '0;
    logic        update_table;
    logic [13:0] branch_address;
    logic [1:0]  branch_prediction_state;
    logic        branch_taken;
    logic        O_mispredict;
    logic [13:0] O_redirect_PC;
    logic [15:0] O_branch_count;
    logic [15:0] O_mispredict_count;

    ceespu_branch_resolver #(.PC_WIDTH(14), .CNT_WIDTH(16)) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .I_stall                 (I_stall),
        .I_flush                 (I_flush),
        .I_fetch_valid           (I_fetch_valid),
        .I_fetch_PC              (I_fetch_PC),
        .I_prediction            (I_prediction),
        .I_prediction_state      (I_prediction_state),
        .I_predicted_target      (I_predicted_target),
        .I_ex_is_branch          (I_ex_is_branch),
        .I_ex_conditional        (I_ex_conditional),
        .I_ex_taken              (I_ex_taken),
        .I_ex_target             (I_ex_target),
        .update_table            (update_table),
        .branch_address          (branch_address),
        .branch_prediction_state (branch_prediction_state),
        .branch_taken            (branch_taken),
        .O_mispredict            (O_mispredict),
        .O_redirect_PC           (O_redirect_PC),
        .O_branch_count          (O_branch_count),
        .O_mispredict_count      (O_mispredict_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Oldest in-flight instruction sits at the back of the queue.
    ent_t        inflight[$];
    logic        exp_upd, exp_mp, exp_tk;
    logic [13:0] exp_addr, exp_redir;
    logic [1:0]  exp_st;
    int          exp_bc, exp_mc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z = '0;
        inflight.delete();
        inflight.push_back(z);
        inflight.push_back(z);
        exp_upd = 0; exp_mp = 0; exp_tk = 0;
        exp_addr = '0; exp_redir = '0; exp_st = '0;
        exp_bc = 0; exp_mc = 0;
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_upd"},   32'(update_table), 32'(exp_upd));
        check({pfx, "_mp"},    32'(O_mispredict), 32'(exp_mp));
        check({pfx, "_addr"},  32'(branch_address), 32'(exp_addr));
        check({pfx, "_st"},    32'(branch_prediction_state), 32'(exp_st));
        check({pfx, "_tk"},    32'(branch_taken), 32'(exp_tk));
        check({pfx, "_redir"}, 32'(O_redirect_PC), 32'(exp_redir));
        check({pfx, "_bc"},    32'(O_branch_count), 32'(exp_bc));
        check({pfx, "_mc"},    32'(O_mispredict_count), 32'(exp_mc));
    endtask

    task automatic step(input logic fv, input logic [13:0] pc, input logic pred,
                        input logic [1:0] st, input logic [13:0] pt,
                        input logic br, input logic cond, input logic tk,
                        input logic [13:0] tgt, input logic stl, input logic fl,
                        input string pfx);
        ent_t e, n, z;
        logic res, mp;
        z = '0;
        I_fetch_valid = fv; I_fetch_PC = pc; I_prediction = pred;
        I_prediction_state = st; I_predicted_target = pt;
        I_ex_is_branch = br; I_ex_conditional = cond; I_ex_taken = tk;
        I_ex_target = tgt; I_stall = stl; I_flush = fl;

        e   = inflight[1];
        res = e.v && br && !stl && !fl;
        mp  = res && ((tk != e.pred) || (tk && e.pred && tgt != e.pt));
        if (fl) begin
            exp_upd = 0; exp_mp = 0;
            inflight[0] = z; inflight[1] = z;
        end else if (stl) begin
            exp_upd = 0; exp_mp = 0;
        end else begin
            exp_upd = res && cond;
            exp_mp  = mp;
            if (res) begin
                exp_addr = e.pc; exp_st = e.st; exp_tk = tk;
                if (exp_bc < c_CNT_MAX) exp_bc++;
            end
            if (mp) begin
                exp_redir = tk ? tgt : e.pc + 14'd1;
                if (exp_mc < c_CNT_MAX) exp_mc++;
                inflight[0] = z; inflight[1] = z;
            end else begin
                n.v = fv; n.pc = pc; n.pred = pred; n.st = st; n.pt = pt;
                void'(inflight.pop_back());
                inflight.push_front(n);
            end
        end
        @(posedge clk);
        #1;
        check_all(pfx);
    endtask

    task automatic bubble(input logic br, input string pfx);
        step(0, '0, 0, '0, '0, br, 1, 1, '0, 0, 0, pfx);
    endtask

    task automatic rstep();
        ent_t e;
        logic tk;
        logic [13:0] tgt;
        e   = inflight[1];
        tk  = 1'($urandom_range(0, 1));
        tgt = ($urandom_range(0, 3) != 0 && e.pred) ? e.pt : 14'($urandom);
        step($urandom_range(0, 4) != 0, 14'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom), 14'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, tk, tgt,
             $urandom_range(0, 9) < 2, $urandom_range(0, 24) == 0, "rnd");
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_upd", 32'(update_table), 32'd0);
        check("rst_bc",  32'(O_branch_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst");

        // Correct taken prediction
        step(1, 14'h0010, 1, 2'd2, 14'h0040, 0, 0, 0, '0, 0, 0, "cp_f");
        bubble(0, "cp_b");
        step(0, '0, 0, '0, '0, 1, 1, 1, 14'h0040, 0, 0, "cp_r");
        check("cp_upd_const",  32'(update_table), 32'd1);
        check("cp_addr_const", 32'(branch_address), 32'h10);
        check("cp_bc_const",   32'(O_branch_count), 32'd1);

        // Direction mispredict; younger D entry and concurrent fetch dropped
        step(1, 14'h0020, 0, 2'd1, 14'h0000, 0, 0, 0, '0, 0, 0, "dm_f");
        step(1, 14'h0021, 0, 2'd1, 14'h0000, 0, 0, 0, '0, 0, 0, "dm_f2");
        step(1, 14'h0022, 0, 2'd1, 14'h0000, 1, 1, 1, 14'h0100, 0, 0, "dm_r");
        check("dm_mp_const",    32'(O_mispredict), 32'd1);
        check("dm_redir_const", 32'(O_redirect_PC), 32'h100);
        bubble(1, "dm_k1");
        bubble(1, "dm_k2");
        check("dm_mc_const", 32'(O_mispredict_count), 32'd1);

        // Not-taken mispredict wrapping past the top of the PC space
        step(1, 14'h3FFF, 1, 2'd3, 14'h0123, 0, 0, 0, '0, 0, 0, "wr_f");
        bubble(0, "wr_b");
        step(0, '0, 0, '0, '0, 1, 1, 0, 14'h0555, 0, 0, "wr_r");
        check("wr_redir_const", 32'(O_redirect_PC), 32'h0);

        // Unconditional register-target branch
        step(1, 14'h0030, 0, 2'd0, 14'h0000, 0, 0, 0, '0, 0, 0, "uc_f");
        bubble(0, "uc_b");
        step(0, '0, 0, '0, '0, 1, 0, 1, 14'h0200, 0, 0, "uc_r");

        // Stall with branch in E, then release
        step(1, 14'h0040, 1, 2'd2, 14'h0050, 0, 0, 0, '0, 0, 0, "st_f");
        bubble(0, "st_b");
        for (int i = 0; i < 3; i++)
            step(0, '0, 0, '0, '0, 1, 1, 1, 14'h0050, 1, 0, "st_h");
        step(0, '0, 0, '0, '0, 1, 1, 1, 14'h0050, 0, 0, "st_r");
        bubble(1, "st_a");

        // Flush with branch in E
        step(1, 14'h0060, 0, 2'd1, 14'h0000, 0, 0, 0, '0, 0, 0, "fl_f");
        step(1, 14'h0061, 0, 2'd1, 14'h0000, 0, 0, 0, '0, 0, 0, "fl_f2");
        step(1, 14'h0062, 0, 2'd1, 14'h0000, 1, 1, 1, 14'h0300, 1, 1, "fl_x");
        bubble(1, "fl_k1");
        bubble(1, "fl_k2");

        for (int i = 0; i < 1500; i++) rstep();

        // Drive the branch counter into saturation with correct predictions
        for (int i = 0; i < 65540; i++)
            step(1, 14'($urandom), 0, 2'($urandom), 14'($urandom), 1, 1, 0, '0, 0, 0, "sat");
        check("sat_bc_const", 32'(O_branch_count), 32'hFFFF);

        // Asynchronous reset away from the clock edge
        #2;
        rst = 1'b0;
        #1;
        check("ar_upd",   32'(update_table), 32'd0);
        check("ar_mp",    32'(O_mispredict), 32'd0);
        check("ar_addr",  32'(branch_address), 32'd0);
        check("ar_redir", 32'(O_redirect_PC), 32'd0);
        check("ar_bc",    32'(O_branch_count), 32'd0);
        check("ar_mc",    32'(O_mispredict_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 500; i++) rstep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ceespu_branch_resolver.md
Name: ceespu_branch_resolver

Overview:
- Downstream companion of the gshare predictor.
- Carries each fetched instruction's prediction metadata (PC, predicted direction, 2-bit counter state, predicted target) through decode to execute.
- At execute, compares the metadata against the actual branch outcome. Produces the predictor's table-update strobe and fields, plus a mispredict/redirect pulse for fetch.
- Maintains saturating branch and mispredict counters for performance monitoring.

Parameters:
- PC_WIDTH, 14, width of PC and target fields (word addresses)
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- I_stall  in  1  pipeline stall; all internal state holds
- I_flush  in  1  external flush (interrupt/exception); kills all in-flight entries
- I_fetch_valid  in  1  fetch stage presents an instruction this cycle
- I_fetch_PC  in  PC_WIDTH  PC of fetched instruction
- I_prediction  in  1  predicted taken (from predictor)
- I_prediction_state  in  2  counter state read for this PC (from predictor)
- I_predicted_target  in  PC_WIDTH  target fetch will use if predicted taken
- I_ex_is_branch  in  1  instruction in execute is a branch
- I_ex_conditional  in  1  that branch is conditional
- I_ex_taken  in  1  actual outcome
- I_ex_target  in  PC_WIDTH  actual target
- update_table  out  1  one-cycle strobe to predictor
- branch_address  out  PC_WIDTH  PC of resolved branch
- branch_prediction_state  out  2  counter state captured at fetch
- branch_taken  out  1  actual outcome
- O_mispredict  out  1  one-cycle redirect pulse
- O_redirect_PC  out  PC_WIDTH  correct next PC, valid with O_mispredict
- O_branch_count  out  CNT_WIDTH  resolved branches
- O_mispredict_count  out  CNT_WIDTH  mispredicted branches

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits 0.
  - All outputs 0: update_table, O_mispredict, branch_*, O_redirect_PC, both counters.
  - Reset mid-operation discards all in-flight entries immediately.
- Pipeline: two metadata registers, D (decode) and E (execute). Each holds valid, PC, pred, state, ptarget.
- Advance (I_stall=0, no flush): D <= fetch inputs with valid=I_fetch_valid; E <= D.
- I_ex_* inputs describe the E entry.
- I_stall=1:
  - D and E hold.
  - update_table and O_mispredict are driven 0 (pulses never stretch).
  - Counters hold.
- Resolution occurs when E.valid=1, I_ex_is_branch=1, I_stall=0 and I_flush=0. Evaluated combinationally; all outputs registered, so visible the cycle after E.
- Mispredict condition: (I_ex_taken != E.pred) OR (I_ex_taken AND E.pred AND I_ex_target != E.ptarget).
- Redirect PC: I_ex_target if taken, else E.PC+1 (modulo 2^PC_WIDTH; wraps at 0x3FFF -> 0x0000).
- Update strobe: update_table=1 only for conditional resolved branches.
  - Unconditional branches never update the table but can still mispredict (register target).
  - branch_address/branch_prediction_state/branch_taken are loaded on any resolution and hold otherwise.
- On mispredict, at the same edge the outputs register:
  - D and E valid bits are cleared.
  - The fetch-stage instruction presented that cycle is dropped (wrong path).
- Simultaneous mispredict and I_fetch_valid: fetch dropped.
- I_flush=1:
  - Clears D and E valid at the edge.
  - Suppresses resolution and pulses that cycle.
  - I_flush has priority over I_stall.
- Counters:
  - O_branch_count increments on each resolution.
  - O_mispredict_count increments on each mispredict.
  - Both saturate at all-ones; no wrap.
- Non-branch or invalid E entry: no outputs pulse; it still advances normally.

Test Plan:
- Correct prediction: fetch PC=0x0010, pred=1, state=2, ptarget=0x0040; two cycles later ex taken=1, target=0x0040, conditional -> next cycle update_table=1, branch_address=0x0010, state=2, taken=1, O_mispredict=0, branch_count=1.
- Direction mispredict: PC=0x0020, pred=0, ex taken=1, target=0x0100 -> O_mispredict=1, O_redirect_PC=0x0100. The two younger entries (D plus dropped fetch) never resolve. mispredict_count=1.
- Not-taken mispredict with wrap: PC=0x3FFF, pred=1, ex taken=0 -> O_redirect_PC=0x0000, update_table=1.
- Unconditional register-target branch: pred=0, ex conditional=0, taken=1, target=0x0200 -> update_table=0, O_mispredict=1, redirect 0x0200.
- Stall and flush:
  - Hold I_stall=1 for 3 cycles with a branch in E -> no pulses during the stall; exactly one resolution after release.
  - Assert I_flush with a branch in E -> no resolution; subsequent E entries are invalid.
- Saturation and reset: preload 0xFFFF resolutions -> branch_count stays 0xFFFF. Drop rst to 0 mid-stream -> all outputs 0 immediately, before the next edge.
